// File: rtl/buffer_uart_pkg.sv
// Shared definitions for the UART line buffers: terminator default, reference
// message and the fill/drain state encoding.
package buffer_uart_pkg;

    localparam logic [7:0] TERM_CHAR_DEF = 8'h0A;

    localparam int MSG_LEN = 13;
    localparam logic [8*MSG_LEN-1:0] MSG = "Hello, World!";

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // True when data equals reference byte idx; positions past the message never match.
    function automatic logic msg_eq(input int idx, input logic [7:0] data);
        if (idx < 0 || idx >= MSG_LEN) begin
            return 1'b0;
        end
        return MSG[8*(MSG_LEN-1-idx) +: 8] == data;
    endfunction

endpackage

// File: rtl/line_mem.sv
// Line storage: BYTE_MAX x 8 register array, synchronous write, combinational read.
module line_mem #(
    parameter int BYTE_MAX = 13,
    localparam int AW = $clog2(BYTE_MAX)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [BYTE_MAX];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/buffer_uart_rx.sv
// Receive-side line buffer: collects bytes into a line, then drains it with last/length.
// Optional reference-string compare is enabled by defining BUFFER_UART_RX_MATCH_EN.
module buffer_uart_rx
    import buffer_uart_pkg::*;
#(
    parameter int          BYTE_MAX  = 13,
    parameter logic [7:0]  TERM_CHAR = TERM_CHAR_DEF,
    localparam int         CNT_W     = $clog2(BYTE_MAX+1),
    localparam int         AW        = $clog2(BYTE_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] out_len,
    output logic             dropped,
    output logic             match
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTE_MAX);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] out_len_q;
    logic             dropped_q;
    logic [CNT_W-1:0] wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_d;
    logic             is_term;
    logic             wr_en;
    logic             last_xfer;
    logic [7:0]       rd_data;

    assign wr_cnt_d  = wr_cnt_q + ONE;
    assign rd_cnt_d  = rd_cnt_q + ONE;
    assign is_term   = (in_data == TERM_CHAR);
    assign wr_en     = (state_q == FILL) && in_valid && !is_term;
    assign last_xfer = (state_q == DRAIN) && out_ready && out_last;

    line_mem #(
        .BYTE_MAX (BYTE_MAX)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (rd_cnt_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            out_len_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            // The UART cannot stall, so anything offered while draining is lost.
            if (in_valid && state_q == DRAIN) begin
                dropped_q <= 1'b1;
            end
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        if (is_term) begin
                            if (wr_cnt_q != '0) begin
                                out_len_q <= wr_cnt_q;
                                state_q   <= DRAIN;
                            end
                        end else begin
                            wr_cnt_q <= wr_cnt_d;
                            if (wr_cnt_d == FULL) begin
                                out_len_q <= FULL;
                                state_q   <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (last_xfer) begin
                            rd_cnt_q <= '0;
                            wr_cnt_q <= '0;
                            state_q  <= FILL;
                        end else begin
                            rd_cnt_q <= rd_cnt_d;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef BUFFER_UART_RX_MATCH_EN
    logic mismatch_q;
    logic match_q;
    logic byte_ok;

    assign byte_ok = msg_eq(int'(wr_cnt_q), in_data);

    // Running compare is kept inverted so "cleared" is the all-equal-so-far state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            if (state_q == FILL && in_valid) begin
                if (is_term) begin
                    if (wr_cnt_q != '0) begin
                        match_q <= !mismatch_q && (wr_cnt_q == FULL);
                    end
                end else begin
                    mismatch_q <= mismatch_q || !byte_ok;
                    if (wr_cnt_d == FULL) begin
                        match_q <= !(mismatch_q || !byte_ok);
                    end
                end
            end
            if (last_xfer) begin
                mismatch_q <= 1'b0;
                match_q    <= 1'b0;
            end
        end
    end

    assign match = match_q;
`else
    assign match = 1'b0;
`endif

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = (state_q == DRAIN) ? rd_data : 8'h00;
    assign out_last  = (state_q == DRAIN) && (rd_cnt_q == out_len_q - ONE);
    assign out_len   = out_len_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_buffer_uart_rx.sv
// Directed bench for buffer_uart_rx: vector table plus hand-written corner sequences.
module tb_buffer_uart_rx;

`ifdef BUFFER_UART_RX_MATCH_EN
    localparam bit M = 1'b1;
`else
    localparam bit M = 1'b0;
`endif

    typedef struct {
        logic       rst_n;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic [3:0] e_len;
        logic       e_drop;
        logic       e_match;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       out_last;
    logic [3:0] out_len;
    logic       dropped;
    logic       match;

    int n_vec = 0;
    int n_err = 0;
    vec_t tab[$];

    string hello = "Hello, World!";
    string helq  = "Hello, World?";

    always #5 clk = ~clk;

    buffer_uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_len   (out_len),
        .dropped   (dropped),
        .match     (match)
    );

    function automatic vec_t mk(input logic rst_n, input logic iv, input logic [7:0] id,
                                input logic ordy, input logic e_ir, input logic e_ov,
                                input logic [7:0] e_od, input logic e_ol, input logic [3:0] e_len,
                                input logic e_drop, input logic e_match);
        vec_t v;
        v.rst_n = rst_n; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
        v.e_len = e_len; v.e_drop = e_drop; v.e_match = e_match;
        return v;
    endfunction

    // Drive one cycle of inputs, then check outputs just after the edge.
    task automatic step(input vec_t v, input string tag);
        rst       = v.rst_n;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_data, out_last, out_len, dropped, match} !==
            {v.e_ir, v.e_ov, v.e_od, v.e_ol, v.e_len, v.e_drop, v.e_match}) begin
            n_err++;
            $display("FAIL %s: got ir=%b ov=%b od=%h last=%b len=%0d drop=%b match=%b, want ir=%b ov=%b od=%h last=%b len=%0d drop=%b match=%b",
                     tag, in_ready, out_valid, out_data, out_last, out_len, dropped, match,
                     v.e_ir, v.e_ov, v.e_od, v.e_ol, v.e_len, v.e_drop, v.e_match);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Reset, with a byte offered that must be ignored.
        tab.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 8'h41, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        // "ABC" + LF, drained at full rate.
        tab.push_back(mk(1, 1, 8'h41, 1, 1, 0, 8'h00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 8'h42, 1, 1, 0, 8'h00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 8'h43, 1, 1, 0, 8'h00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 8'h0A, 1, 0, 1, 8'h41, 0, 3, 0, 0));
        tab.push_back(mk(1, 0, 8'h00, 1, 0, 1, 8'h42, 0, 3, 0, 0));
        tab.push_back(mk(1, 0, 8'h00, 1, 0, 1, 8'h43, 1, 3, 0, 0));
        tab.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 3, 0, 0));
        // Full line without terminator, matching reference.
        for (int i = 0; i < 12; i++)
            tab.push_back(mk(1, 1, hello[i], 0, 1, 0, 8'h00, 0, 3, 0, 0));
        tab.push_back(mk(1, 1, hello[12], 0, 0, 1, hello[0], 0, 13, 0, M));
        for (int k = 1; k < 13; k++)
            tab.push_back(mk(1, 0, 8'h00, 1, 0, 1, hello[k], k == 12, 13, 0, M));
        tab.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 13, 0, 0));
        // Full line differing in the last byte; a byte offered on the final transfer is dropped.
        for (int i = 0; i < 12; i++)
            tab.push_back(mk(1, 1, helq[i], 0, 1, 0, 8'h00, 0, 13, 0, 0));
        tab.push_back(mk(1, 1, helq[12], 0, 0, 1, helq[0], 0, 13, 0, 0));
        for (int k = 1; k < 13; k++)
            tab.push_back(mk(1, 0, 8'h00, 1, 0, 1, helq[k], k == 12, 13, 0, 0));
        tab.push_back(mk(1, 1, 8'h78, 1, 1, 0, 8'h00, 0, 13, 1, 0));
        // LF right after a full line is an empty line.
        tab.push_back(mk(1, 1, 8'h0A, 1, 1, 0, 8'h00, 0, 13, 1, 0));
        tab.push_back(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 13, 1, 0));
        // Reset clears dropped and the length.
        tab.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0));

        @(negedge clk);
        foreach (tab[i]) step(tab[i], $sformatf("vec%0d", i));

        // Stall mid-drain while the UART keeps pulsing bytes.
        step(mk(1, 1, 8'h50, 0, 1, 0, 8'h00, 0, 0, 0, 0), "stall_fill_P");
        step(mk(1, 1, 8'h51, 0, 1, 0, 8'h00, 0, 0, 0, 0), "stall_fill_Q");
        step(mk(1, 1, 8'h52, 0, 1, 0, 8'h00, 0, 0, 0, 0), "stall_fill_R");
        step(mk(1, 1, 8'h0A, 0, 0, 1, 8'h50, 0, 3, 0, 0), "stall_term");
        step(mk(1, 0, 8'h00, 1, 0, 1, 8'h51, 0, 3, 0, 0), "stall_first_xfer");
        for (int c = 0; c < 5; c++)
            step(mk(1, c[0] == 1'b0, 8'h55, 0, 0, 1, 8'h51, 0, 3, 1, 0), $sformatf("stall_hold%0d", c));
        step(mk(1, 0, 8'h00, 1, 0, 1, 8'h52, 1, 3, 1, 0), "stall_resume");
        step(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 3, 1, 0), "stall_done");

        // Lone LF, then a reset in the middle of "XY", then "Z" + LF.
        step(mk(1, 1, 8'h0A, 1, 1, 0, 8'h00, 0, 3, 1, 0), "lone_lf");
        step(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 3, 1, 0), "lone_lf_idle");
        step(mk(1, 1, 8'h58, 1, 1, 0, 8'h00, 0, 3, 1, 0), "xy_X");
        step(mk(1, 1, 8'h59, 1, 1, 0, 8'h00, 0, 3, 1, 0), "xy_Y");
        step(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0, 0), "xy_reset");
        step(mk(1, 1, 8'h5A, 1, 1, 0, 8'h00, 0, 0, 0, 0), "z_byte");
        step(mk(1, 1, 8'h0A, 0, 0, 1, 8'h5A, 1, 1, 0, 0), "z_term");
        step(mk(1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1, 0, 0), "z_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
